nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//   Sequencer that reuses one 4-bit parallel_adder slice to add two WIDTH-bit operands
//   one nibble per cycle, LSB nibble first, with the carry held in a register between cycles.
//   Wraps the slice in valid/ready handshakes on input and output, so wide additions
//   cost one small adder plus WIDTH/4 cycles of latency.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; must be a multiple of 4 and >= 4
// PORTS
//   clk        in   1      single clock; all state updates on its rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands a, b and cin are presented
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry into nibble 0
//   out_valid  out  1      sum, cout and ovf are valid and held
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
//   busy       out  1      high in ADD and DONE
// BEHAVIOUR
//   - One clock, clk. Reset is synchronous and active-high on rst.
//   - Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0,
//     nibble index=0, carry register=0.
//   - States:
//     - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and cin (cin goes to the carry
//       register), set idx=0, go to ADD.
//     - ADD: each cycle, the slice adds a[idx*4+:4] + b[idx*4+:4] + carry.
//       The slice sum is written to sum[idx*4+:4] and the slice carry to the carry register.
//       On idx==WIDTH/4-1: set cout=slice carry, set ovf=(carry into bit WIDTH-1)^(slice carry),
//       go to DONE. Otherwise idx++.
//     - DONE: out_valid=1. sum, cout and ovf are held stable until out_valid&&out_ready,
//       then go to IDLE.
//   - Latency: with the accept edge at cycle 0, out_valid is first high after edge WIDTH/4.
//     With WIDTH=4, the single ADD cycle goes directly to DONE.
//   - Throughput: one addition per WIDTH/4+2 cycles when out_ready is held high.
//     No new operand is accepted in the same cycle a result retires.
//   - in_valid while busy: ignored. in_ready=0, nothing is latched, no error.
//   - Operand inputs may change after acceptance; only the latched copies are used.
//   - sum is cleared to 0 on accept, so partial nibbles are visible only as internal state.
//     Downstream may use sum only while out_valid=1.
//   - rst during ADD or DONE: the next cycle is IDLE with the reset values;
//     the in-flight result is discarded. rst overrides any coincident handshake.
//   - A WIDTH that is not a multiple of 4, or is 0, is an elaboration error
//     (generate-time check).
// STRUCTURE
//   - Shared package: state encoding localparams ST_IDLE/ST_ADD/ST_DONE, NIBBLE=4,
//     and a function nibbles(WIDTH) = WIDTH/NIBBLE.
//   - One sub-module: a single instance of parallel_adder (4-bit ripple of full_adder)
//     as the datapath slice. Its carry_in is the carry register; its carry output feeds
//     the carry register.
//   - Rest is local: operand registers, idx counter of width $clog2(WIDTH/4) (min 1),
//     FSM, result register.
//   - ovf needs the carry into bit WIDTH-1. Derive it inside the last nibble as
//     a[W-1]^b[W-1]^sum[W-1].
// TESTING (WIDTH=16 unless stated)
//   1. a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0, ovf=0;
//      out_valid high exactly 4 cycles after the accept edge.
//   2. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0
//      (carry ripples across all 4 nibble cycles).
//   3. a=16'h7FFF, b=16'h0000, cin=1 -> sum=16'h8000, cout=0, ovf=1.
//   4. Backpressure: hold out_ready=0 for 6 cycles in DONE -> sum/cout/ovf stable and
//      in_ready=0; new in_valid pulses are ignored. Raise out_ready -> IDLE next cycle.
//   5. Assert rst for 1 cycle on the 2nd ADD cycle of a=16'hFFFF, b=16'hFFFF
//      -> next cycle IDLE, out_valid=0, busy=0, sum=0. A following accept of
//      a=1, b=2 yields sum=3.
//   6. WIDTH=4: a=4'hF, b=4'h1, cin=1 -> sum=4'h1, cout=1; out_valid 1 cycle after accept.
//   Random: 2000 back-to-back transactions with random out_ready stalls,
//   checked against a WIDTH+1-bit reference sum.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, slice width and
// the helper that turns an operand width into a nibble count.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nibbles(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_parallel_adder.sv
// 4-bit ripple-carry slice built from full adders; the serial sequencer reuses a
// single instance of it for every nibble.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);
  logic [4:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign carry_out = carry[4];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle through a shared 4-bit slice,
// with valid/ready handshakes on both the operand and the result side.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = nibbles(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if (WIDTH < NIBBLE || (WIDTH % NIBBLE) != 0) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a non-zero multiple of 4");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q, cout_q, ovf_q;
  logic [NIBBLE-1:0] a_nib, b_nib, slice_sum;
  logic              slice_co;
  logic              last_nib;

  assign a_nib    = a_q[idx_q*NIBBLE +: NIBBLE];
  assign b_nib    = b_q[idx_q*NIBBLE +: NIBBLE];
  assign last_nib = (idx_q == LAST_IDX);

  parallel_adder u_slice (
    .a         (a_nib),
    .b         (b_nib),
    .carry_in  (carry_q),
    .sum       (slice_sum),
    .carry_out (slice_co)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_ADD;
      end
      ST_ADD: begin
        busy = 1'b1;
        if (last_nib) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        ST_ADD: begin
          sum_q[idx_q*NIBBLE +: NIBBLE] <= slice_sum;
          carry_q                       <= slice_co;
          if (last_nib) begin
            cout_q <= slice_co;
            // Carry into the MSB is recovered from the MSB's own inputs and sum bit.
            ovf_q  <= (a_nib[NIBBLE-1] ^ b_nib[NIBBLE-1] ^ slice_sum[NIBBLE-1]) ^ slice_co;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=16 and WIDTH=4, plus a
// randomised run against a WIDTH+1-bit reference sum.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [15:0] a, b, sum;
  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4, busy4;
  logic [3:0]  a4, b4, sum4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
  endtask

  // Full transaction on the 16-bit instance; inputs driven and outputs sampled on negedges.
  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, input logic [15:0] es, input logic ec,
                       input logic eo, input int stall);
    int n;
    check(tag, "in_ready_idle", in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, "out_valid", out_valid, 1);
    check(tag, "latency", n, 4);
    check(tag, "sum", sum, es);
    check(tag, "cout", cout, ec);
    check(tag, "ovf", ovf, eo);
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check(tag, "in_ready_after", in_ready, 1);
    check(tag, "out_valid_after", out_valid, 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc, eo;
    logic [16:0] ref_sum;
    int          n;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset", "in_ready", in_ready, 1);
    check("reset", "out_valid", out_valid, 0);
    check("reset", "busy", busy, 0);
    check("reset", "sum", sum, 0);
    check("reset", "cout", cout, 0);
    check("reset", "ovf", ovf, 0);
    check("reset4", "in_ready", in_ready4, 1);

    run16("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run16("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run16("t3", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 0);

    // Backpressure: result held for 6 cycles, new operands ignored.
    a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4", "out_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      check("t4", "sum", sum, 16'h0000);
      check("t4", "cout", cout, 1);
      check("t4", "ovf", ovf, 1);
      check("t4", "in_ready", in_ready, 0);
      check("t4", "out_valid_held", out_valid, 1);
      a = 16'h1111; b = 16'h2222; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t4", "sum_end", sum, 16'h0000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4", "in_ready_after", in_ready, 1);
    check("t4", "busy_after", busy, 0);

    // Reset on the second ADD cycle discards the in-flight addition.
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5", "busy_mid", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5", "in_ready", in_ready, 1);
    check("t5", "out_valid", out_valid, 0);
    check("t5", "busy", busy, 0);
    check("t5", "sum", sum, 0);
    run16("t5b", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

    // WIDTH=4: a single ADD cycle, result one edge after accept.
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    check("t6", "out_valid_add", out_valid4, 0);
    check("t6", "busy", busy4, 1);
    @(negedge clk);
    check("t6", "out_valid", out_valid4, 1);
    check("t6", "sum", sum4, 4'h1);
    check("t6", "cout", cout4, 1);
    check("t6", "ovf", ovf4, 0);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check("t6", "in_ready_after", in_ready4, 1);

    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      eo = (ra[15] == rb[15]) && (ref_sum[15] != ra[15]);
      run16("rand", ra, rb, rc, ref_sum[15:0], ref_sum[16], eo, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
